// File: rtl/mash_stream_decoder_pkg.sv
// Shared types and constants for the MASH stream decoder.
// Optional build macro used by this block: MASH_DEC_MINMAX_EN (min/max trackers).
package mash_stream_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_REPORT
    } dec_state_t;

    localparam int unsigned ACC_W  = 20;
    localparam int unsigned FRAC_W = 12;
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned SMP_W  = 8;

    localparam logic [3:0] WIN_MIN = 4'd4;
    localparam logic [3:0] WIN_MAX = 4'd12;

    // Restrict the requested window exponent to the supported range.
    function automatic logic [3:0] clamp_win(input logic [3:0] k);
        logic [3:0] r;
        if (k < WIN_MIN) begin
            r = WIN_MIN;
        end else if (k > WIN_MAX) begin
            r = WIN_MAX;
        end else begin
            r = k;
        end
        return r;
    endfunction

endpackage

// File: rtl/mash_stream_decoder_accum.sv
// Window accumulator for the MASH stream decoder: running sum, sample
// counter, last-sample detection and (when MASH_DEC_MINMAX_EN is defined)
// per-window min/max trackers.
module mash_dec_accum
    import mash_stream_decoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [SMP_W-1:0]  sample,
    input  logic [3:0]        win_log2,
    output logic [ACC_W-1:0]  acc_next,
    output logic [SMP_W-1:0]  min_next,
    output logic [SMP_W-1:0]  max_next,
    output logic              last
);

    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] last_idx;

    // Sum including the current sample, and detection of the 2^k-th sample.
    always_comb begin
        acc_next = acc + ACC_W'(sample);
        last_idx = CNT_ONES >> (4'(CNT_W) - win_log2);
        last     = en && (count == last_idx);
    end

    // Running sum and sample counter, cleared at the start of each window.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc   <= '0;
            count <= '0;
        end else if (en) begin
            acc   <= acc_next;
            count <= count + CNT_W'(1);
        end
    end

`ifdef MASH_DEC_MINMAX_EN
    logic [SMP_W-1:0] min_q;
    logic [SMP_W-1:0] max_q;

    // Extremes including the current sample.
    always_comb begin
        min_next = (sample < min_q) ? sample : min_q;
        max_next = (sample > max_q) ? sample : max_q;
    end

    // Extreme trackers, primed so the first sample always replaces them.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            min_q <= '1;
            max_q <= '0;
        end else if (en) begin
            min_q <= min_next;
            max_q <= max_next;
        end
    end
`else
    assign min_next = '0;
    assign max_next = '0;
`endif

endmodule

// File: rtl/mash_stream_decoder.sv
// MASH division-ratio stream decoder: averages 2^k samples into an 8.12
// fixed-point result and reports it with a valid/ready handshake.
// Build macro: MASH_DEC_MINMAX_EN enables per-window min/max reporting;
// without it o_min/o_max stay at zero.
module mash_stream_decoder
    import mash_stream_decoder_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [3:0]        i_win_log2,
    input  logic              i_mash_valid,
    input  logic [SMP_W-1:0]  i_mash_out,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_valid,
    output logic [SMP_W-1:0]  o_int,
    output logic [FRAC_W-1:0] o_frac,
    output logic [SMP_W-1:0]  o_min,
    output logic [SMP_W-1:0]  o_max,
    output logic              o_overrun
);

    dec_state_t       state;
    logic [3:0]       k_lat;
    logic             accept_start;
    logic             sample_en;
    logic             last;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] scaled;
    logic [SMP_W-1:0] min_next;
    logic [SMP_W-1:0] max_next;

    assign accept_start = (state == ST_IDLE) && i_start;
    assign sample_en    = (state == ST_ACCUM) && i_mash_valid;

    // Normalise the 2^k-sample sum to a 12-bit fraction; cannot overflow.
    always_comb begin
        scaled = acc_next << (4'(FRAC_W) - k_lat);
    end

    mash_dec_accum u_accum (
        .clk      (i_clk),
        .rst      (i_rst),
        .clear    (accept_start),
        .en       (sample_en),
        .sample   (i_mash_out),
        .win_log2 (k_lat),
        .acc_next (acc_next),
        .min_next (min_next),
        .max_next (max_next),
        .last     (last)
    );

    // Control FSM with registered result and status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            k_lat     <= WIN_MIN;
            o_busy    <= 1'b0;
            o_valid   <= 1'b0;
            o_int     <= '0;
            o_frac    <= '0;
            o_min     <= '0;
            o_max     <= '0;
            o_overrun <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        k_lat     <= clamp_win(i_win_log2);
                        o_overrun <= 1'b0;
                        o_busy    <= 1'b1;
                        state     <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (last) begin
                        o_int   <= scaled[ACC_W-1:FRAC_W];
                        o_frac  <= scaled[FRAC_W-1:0];
                        o_min   <= min_next;
                        o_max   <= max_next;
                        o_busy  <= 1'b0;
                        o_valid <= 1'b1;
                        state   <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (i_mash_valid) begin
                        o_overrun <= 1'b1;
                    end
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mash_stream_decoder.sv
// Randomised self-checking bench for mash_stream_decoder against a
// window-average reference model.
module tb_mash_stream_decoder;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [3:0]  i_win_log2;
    logic        i_mash_valid;
    logic [7:0]  i_mash_out;
    logic        i_ready;
    logic        o_busy;
    logic        o_valid;
    logic [7:0]  o_int;
    logic [11:0] o_frac;
    logic [7:0]  o_min;
    logic [7:0]  o_max;
    logic        o_overrun;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 i_clk = ~i_clk;

    mash_stream_decoder dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_win_log2   (i_win_log2),
        .i_mash_valid (i_mash_valid),
        .i_mash_out   (i_mash_out),
        .i_ready      (i_ready),
        .o_busy       (o_busy),
        .o_valid      (o_valid),
        .o_int        (o_int),
        .o_frac       (o_frac),
        .o_min        (o_min),
        .o_max        (o_max),
        .o_overrun    (o_overrun)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int clamp_k(input int k);
        if (k < 4) return 4;
        if (k > 12) return 12;
        return k;
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"},    32'(o_busy),    0);
        check_val({tag, "_valid"},   32'(o_valid),   0);
        check_val({tag, "_int"},     32'(o_int),     0);
        check_val({tag, "_frac"},    32'(o_frac),    0);
        check_val({tag, "_min"},     32'(o_min),     0);
        check_val({tag, "_max"},     32'(o_max),     0);
        check_val({tag, "_overrun"}, 32'(o_overrun), 0);
    endtask

    // pat: 0 constant base, 1 alternating base/base+1, 2 random.
    // gap_mod: 0 no gaps, else valid low every gap_mod-th cycle.
    // hold: cycles with i_ready low in REPORT (0: ready already high).
    task automatic run_window(input int kin, input int pat, input int gap_mod,
                              input int hold, input int n_ovr, input int base);
        int     k, n, got, cyc, d, mn, mx, exp_int, exp_frac, exp_min, exp_max;
        longint sum, exp_scaled;
        bit     exp_ovr;
        k = clamp_k(kin);
        n = 1 << k;
        i_ready      = (hold == 0);
        i_win_log2   = kin[3:0];
        i_start      = 1'b1;
        i_mash_valid = 1'b0;
        step();
        i_start    = 1'b0;
        i_win_log2 = 4'($urandom);
        check_val("busy_rise", 32'(o_busy), 1);
        check_val("ovr_clear", 32'(o_overrun), 0);
        sum = 0; mn = 255; mx = 0; got = 0; cyc = 0;
        while (got < n) begin
            cyc++;
            i_start = ($urandom_range(0, 6) == 0);
            if (gap_mod != 0 && (cyc % gap_mod) == 0) begin
                i_mash_valid = 1'b0;
                i_mash_out   = 8'($urandom);
            end else begin
                case (pat)
                    0:       d = base;
                    1:       d = base + (got % 2);
                    default: d = $urandom_range(0, 255);
                endcase
                i_mash_valid = 1'b1;
                i_mash_out   = d[7:0];
                sum += d;
                if (d < mn) mn = d;
                if (d > mx) mx = d;
                got++;
            end
            step();
            if (got == n - 1 && i_mash_valid) check_val("valid_early", 32'(o_valid), 0);
        end
        i_mash_valid = 1'b0;
        i_start      = 1'b0;
        exp_scaled = (sum * 4096) / n;
        exp_int    = int'(exp_scaled / 4096);
        exp_frac   = int'(exp_scaled % 4096);
`ifdef MASH_DEC_MINMAX_EN
        exp_min = mn;
        exp_max = mx;
`else
        exp_min = 0;
        exp_max = 0;
`endif
        check_val("valid_rise", 32'(o_valid), 1);
        check_val("busy_fall",  32'(o_busy),  0);
        check_val("int",        32'(o_int),   exp_int);
        check_val("frac",       32'(o_frac),  exp_frac);
        check_val("min",        32'(o_min),   exp_min);
        check_val("max",        32'(o_max),   exp_max);
        exp_ovr = 1'b0;
        for (int h = 0; h < hold; h++) begin
            i_mash_valid = (h < n_ovr);
            i_mash_out   = 8'($urandom);
            i_start      = 1'($urandom_range(0, 1));
            if (i_mash_valid) exp_ovr = 1'b1;
            step();
            check_val("hold_valid", 32'(o_valid),   1);
            check_val("hold_int",   32'(o_int),     exp_int);
            check_val("hold_frac",  32'(o_frac),    exp_frac);
            check_val("hold_min",   32'(o_min),     exp_min);
            check_val("hold_max",   32'(o_max),     exp_max);
            check_val("hold_ovr",   32'(o_overrun), 32'(exp_ovr));
        end
        // Transfer edge, with a coincident start that must be ignored.
        i_ready      = 1'b1;
        i_start      = 1'b1;
        i_mash_valid = 1'($urandom_range(0, 1));
        i_mash_out   = 8'($urandom);
        if (i_mash_valid) exp_ovr = 1'b1;
        step();
        check_val("valid_fall",  32'(o_valid),   0);
        check_val("start_ign",   32'(o_busy),    0);
        check_val("xfer_ovr",    32'(o_overrun), 32'(exp_ovr));
        i_ready      = 1'b0;
        i_start      = 1'b0;
        i_mash_valid = 1'b0;
        step();
        check_val("idle_busy",   32'(o_busy),    0);
        check_val("idle_ovr",    32'(o_overrun), 32'(exp_ovr));
    endtask

    task automatic reset_mid_window();
        i_win_log2 = 4'd4;
        i_start    = 1'b1;
        step();
        i_start = 1'b0;
        for (int s = 0; s < 7; s++) begin
            i_mash_valid = 1'b1;
            i_mash_out   = 8'($urandom_range(1, 255));
            step();
        end
        i_rst        = 1'b1;
        i_mash_valid = 1'b0;
        step();
        check_all_zero("mid_rst");
        i_rst = 1'b0;
        step();
        check_val("post_rst_busy", 32'(o_busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_win_log2   = 4'd4;
        i_mash_valid = 1'b0;
        i_mash_out   = 8'd0;
        i_ready      = 1'b0;
        step();
        step();
        check_all_zero("reset");
        i_rst = 1'b0;
        step();

        run_window(4,  0, 0, 0,  0, 100);
        run_window(4,  1, 3, 2,  0, 100);
        run_window(12, 0, 0, 0,  0, 255);
        run_window(2,  2, 0, 1,  1, 0);
        run_window(15, 2, 4, 0,  0, 0);
        run_window(4,  0, 0, 10, 3, 77);
        run_window(5,  2, 0, 0,  0, 0);
        reset_mid_window();
        run_window(4,  2, 0, 3,  1, 0);
        for (int r = 0; r < 4; r++) begin
            run_window($urandom_range(0, 15), 2,
                       ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(2, 5),
                       $urandom_range(0, 4), $urandom_range(0, 2), 0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/mash_stream_decoder.md
# mash_stream_decoder

Measurement receiver for the MASH modulator's 8-bit division-ratio stream. It accumulates the per-cycle divider words over a programmable window of 2^k samples and reports the recovered average as integer plus 12-bit fraction. It also reports the min/max sample seen, which bounds the MASH order in use. It sits on the modulator output bus and serves both self-test and bring-up of the fractional-N loop.

## Interface
Parameters:
- none; widths are fixed constants in the shared package.

Ports (clock is i_clk; reset is i_rst, synchronous, active-high):
- i_clk  in  1  system clock, same domain as the modulator
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  start one measurement window (honoured only in IDLE)
- i_win_log2  in  4  window exponent k; clamped to 4..12, latched on accepted start
- i_mash_valid  in  1  sample qualifier
- i_mash_out  in  8  divider word from modulator
- i_ready  in  1  consumer accepts result
- o_busy  out  1  high in ACCUM
- o_valid  out  1  result valid, held until i_ready
- o_int  out  8  averaged integer part
- o_frac  out  12  averaged fractional part (LSB = 2^-12)
- o_min  out  8  smallest sample in window
- o_max  out  8  largest sample in window
- o_overrun  out  1  sticky: a sample arrived while in REPORT

## Operation
- States: IDLE, ACCUM, REPORT.
- IDLE: on i_start, latch clamped k, clear acc (20 b) and count (12 b), set min=8'hFF and max=8'h00, clear o_overrun, go to ACCUM.
- ACCUM: each cycle with i_mash_valid: acc += sample, count++, update min/max. When count == 2^k−1 and valid (last sample), compute result and go to REPORT. Cycles without valid do nothing. i_start is ignored.
- Result: scaled = acc << (12−k), 20 b; o_int = scaled[19:12], o_frac = scaled[11:0]. No overflow is possible: 255·4096 < 2^20.
- REPORT: o_valid=1 and outputs are held stable. i_ready high causes a transfer, and the block goes to IDLE next cycle. i_ready may already be high when o_valid rises. Any i_mash_valid in REPORT sets o_overrun, and the sample is discarded. i_start is ignored.
- Reset, including mid-window: state goes to IDLE and every output register goes to 0 (o_busy, o_valid, o_int, o_frac, o_min, o_max, o_overrun).

## Timing
- o_busy rises the cycle after an accepted i_start.
- o_valid rises the cycle after the clock edge that accepts the 2^k-th valid sample.
- Result transfer: o_valid & i_ready at an edge; o_valid is 0 in the following cycle.
- Earliest new start: the cycle after transfer (IDLE). A start coincident with the transfer edge is ignored.
- Throughput per window: 2^k valid samples + 1 REPORT cycle minimum + 1 IDLE cycle.

## Configuration
- MASH_DEC_MINMAX_EN defined: min/max trackers are built, and o_min/o_max report per-window extremes.
- Not defined: trackers are removed, and o_min/o_max are tied to 8'h00 in all states. Average and handshake are unchanged.

## Structure
- Shared package contents:
  - state enum (IDLE/ACCUM/REPORT)
  - constants ACC_W=20, FRAC_W=12, CNT_W=12, WIN_MIN=4, WIN_MAX=12
- One sub-module, mash_dec_accum: accumulator, window counter, min/max, and last-sample flag.
- The top holds the FSM, k latch, scaling shifter and output registers.

## Test plan
- k=4, 16 valid samples of 100 → o_int=100, o_frac=0, min=max=100, o_valid one cycle after 16th sample.
- k=4, alternating 100/101 with valid gaps every 3rd cycle → o_int=100, o_frac=12'h800, min=100, max=101.
- k=12, 4096 samples of 255 → o_int=255, o_frac=0, no wrap. i_win_log2=2 → 16-sample window; i_win_log2=15 → 4096-sample window.
- k=4 result held with i_ready low 10 cycles, 3 valid samples meanwhile → outputs stable, o_overrun=1. Then i_ready=1 → IDLE; next i_start clears o_overrun.
- i_start pulses during ACCUM and REPORT → ignored, window length unchanged.
- i_rst asserted after 7 samples of a k=4 window → all outputs 0 next cycle, state IDLE. A fresh 16-sample window afterwards yields the correct average.
